// File: rtl/gb_wr_sched.sv
// GB write scheduler: Wei-priority/round-robin arbiter, Gray-coded write handshake FSM, burst counter.
// Optional bank_rdy watchdog selected by GB_WR_SCHED_TIMEOUT_EN.
module gb_wr_sched #(
    parameter int unsigned ID_W   = 6,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned TO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [4*ID_W-1:0] req_id,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic [3:0]        dat_vld,
    input  logic              bank_rdy,
    output logic [1:0]        State_Wr,
    output logic [ID_W-1:0]   Wr_ID,
    output logic              Wr_Req,
    output logic [3:0]        gnt,
    output logic              wr_en,
    output logic [3:0]        done,
    output logic              err
);

    typedef enum logic [1:0] {
        StIdle         = 2'b00,
        StReqReady     = 2'b01,
        StReadyToWrite = 2'b11,
        StWrite        = 2'b10
    } state_e;

    state_e             state_q;
    logic [1:0]         idx_q;
    logic [1:0]         rr_ptr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;

    logic [1:0]         win;
    logic [1:0]         c1, c2, c3;
    logic [ID_W-1:0]    win_id;
    logic [LEN_W-1:0]   win_len;

`ifdef GB_WR_SCHED_TIMEOUT_EN
    localparam int unsigned ToW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TO_CYC - 1);
    logic [ToW-1:0] to_q;
`endif

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    // Round-robin over 1..3 starting after the last non-Wei winner
    always_comb begin
        c1 = rr_next(rr_ptr_q);
        c2 = rr_next(c1);
        c3 = rr_next(c2);
        win = 2'd0;
        if (req[0])       win = 2'd0;
        else if (req[c1]) win = c1;
        else if (req[c2]) win = c2;
        else if (req[c3]) win = c3;
        win_id  = req_id[win*ID_W +: ID_W];
        win_len = req_len[win*LEN_W +: LEN_W];
        if (win_len == '0) win_len = LEN_W'(1);
    end

    assign State_Wr = state_q;
    assign wr_en    = (state_q == StWrite) && dat_vld[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            Wr_ID    <= '0;
            Wr_Req   <= 1'b0;
            gnt      <= 4'b0;
            done     <= 4'b0;
            err      <= 1'b0;
            idx_q    <= 2'd0;
            rr_ptr_q <= 2'd3;
            len_q    <= '0;
            cnt_q    <= '0;
`ifdef GB_WR_SCHED_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            done <= 4'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req != 4'b0) begin
                        idx_q  <= win;
                        Wr_ID  <= win_id;
                        len_q  <= win_len;
                        Wr_Req <= 1'b1;
                        if (win != 2'd0) rr_ptr_q <= win;
`ifdef GB_WR_SCHED_TIMEOUT_EN
                        to_q   <= '0;
`endif
                        state_q <= StReqReady;
                    end
                end
                StReqReady: begin
                    if (bank_rdy) begin
                        Wr_Req  <= 1'b0;
                        gnt     <= 4'b0001 << idx_q;
                        state_q <= StReadyToWrite;
                    end
`ifdef GB_WR_SCHED_TIMEOUT_EN
                    else if (to_q == ToLast) begin
                        err     <= 1'b1;
                        Wr_Req  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        to_q <= to_q + ToW'(1);
                    end
`endif
                end
                StReadyToWrite: begin
                    cnt_q   <= '0;
                    state_q <= StWrite;
                end
                StWrite: begin
                    if (wr_en) begin
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            done    <= 4'b0001 << idx_q;
                            gnt     <= 4'b0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
